// File: rtl/quad_ud_driver_if.sv
// Control/status bundle between an encoder front end and its 74169-style counter driver.
interface quad_ud_driver_if #(
  parameter int unsigned POS_W = 4
);
  logic             QA;
  logic             QB;
  logic             PRESET_REQ;
  logic [POS_W-1:0] PRESET_VAL;
  logic             ERR_CLR;
  logic             U_DB;
  logic             ENPB;
  logic             ENTB;
  logic             LOADB;
  logic             ERR;
  logic [POS_W-1:0] POS;

  modport master (
    output QA, QB, PRESET_REQ, PRESET_VAL, ERR_CLR,
    input  U_DB, ENPB, ENTB, LOADB, ERR, POS
  );

  modport slave (
    input  QA, QB, PRESET_REQ, PRESET_VAL, ERR_CLR,
    output U_DB, ENPB, ENTB, LOADB, ERR, POS
  );
endinterface

// File: rtl/quad_ud_driver.sv
// Quadrature decoder that turns filtered QA/QB edges into one-cycle enable strobes
// and preset loads for a 74169-style up/down counter, with a shadow position.
module quad_ud_driver #(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned POS_W    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  quad_ud_driver_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       warm_q, warm_d;
  logic [1:0]       samp_q, samp_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [1:0]       acc_q, acc_d;
  logic             acc_vld_q, acc_vld_d;
  logic             step_v_q, step_v_d;
  logic             step_up_q, step_up_d;
  logic             pend_v_q, pend_v_d;
  logic             pend_up_q, pend_up_d;
  logic             u_db_q, u_db_d;
  logic             en_b_q, en_b_d;
  logic             load_b_q, load_b_d;
  logic             err_q, err_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic             illegal;
  logic             ovf;
  logic             issue_v;
  logic             issue_up;

  // Successor of a phase state in the A-leads-B (up) direction.
  function automatic logic [1:0] next_up(input logic [1:0] s);
    return {~s[0], s[1]};
  endfunction

  always_comb begin
    sync1_d   = {bus.QA, bus.QB};
    sync2_d   = sync1_q;
    warm_d    = {warm_q[0], 1'b1};
    samp_d    = samp_q;
    run_d     = run_q;
    acc_d     = acc_q;
    acc_vld_d = acc_vld_q;
    step_v_d  = 1'b0;
    step_up_d = step_up_q;
    pend_v_d  = pend_v_q;
    pend_up_d = pend_up_q;
    u_db_d    = u_db_q;
    en_b_d    = 1'b1;
    load_b_d  = 1'b1;
    pos_d     = pos_q;
    illegal   = 1'b0;
    ovf       = 1'b0;
    issue_v   = 1'b0;
    issue_up  = 1'b0;

    // Run-length filter; cleared synchronizer contents are not counted as samples.
    if (warm_q[1]) begin
      samp_d = sync2_q;
      if (sync2_q == samp_q) begin
        if (run_q != CNT_W'(FILT_LEN)) run_d = run_q + CNT_W'(1);
      end else begin
        run_d = CNT_W'(1);
      end
    end

    // Decode an accepted level against the previous reference.
    if (run_q == CNT_W'(FILT_LEN)) begin
      if (!acc_vld_q) begin
        acc_vld_d = 1'b1;
        acc_d     = samp_q;
      end else if (samp_q != acc_q) begin
        acc_d = samp_q;
        if (samp_q == next_up(acc_q)) begin
          step_v_d  = 1'b1;
          step_up_d = 1'b1;
        end else if (acc_q == next_up(samp_q)) begin
          step_v_d  = 1'b1;
          step_up_d = 1'b0;
        end else begin
          illegal = 1'b1;
        end
      end
    end

    // Load wins the output cycle; a colliding step waits in the one-deep slot.
    if (bus.PRESET_REQ) begin
      load_b_d = 1'b0;
      pos_d    = bus.PRESET_VAL;
      if (step_v_q) begin
        if (pend_v_q) begin
          ovf = 1'b1;
        end else begin
          pend_v_d  = 1'b1;
          pend_up_d = step_up_q;
        end
      end
    end else if (pend_v_q) begin
      issue_v  = 1'b1;
      issue_up = pend_up_q;
      if (step_v_q) pend_up_d = step_up_q;
      else          pend_v_d  = 1'b0;
    end else if (step_v_q) begin
      issue_v  = 1'b1;
      issue_up = step_up_q;
    end

    if (issue_v) begin
      en_b_d = 1'b0;
      u_db_d = issue_up;
      pos_d  = issue_up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end

    err_d = err_q | illegal | ovf;
    if (bus.ERR_CLR) err_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      warm_q    <= 2'b00;
      samp_q    <= 2'b00;
      run_q     <= '0;
      acc_q     <= 2'b00;
      acc_vld_q <= 1'b0;
      step_v_q  <= 1'b0;
      step_up_q <= 1'b1;
      pend_v_q  <= 1'b0;
      pend_up_q <= 1'b1;
      u_db_q    <= 1'b1;
      en_b_q    <= 1'b1;
      load_b_q  <= 1'b1;
      err_q     <= 1'b0;
      pos_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      warm_q    <= warm_d;
      samp_q    <= samp_d;
      run_q     <= run_d;
      acc_q     <= acc_d;
      acc_vld_q <= acc_vld_d;
      step_v_q  <= step_v_d;
      step_up_q <= step_up_d;
      pend_v_q  <= pend_v_d;
      pend_up_q <= pend_up_d;
      u_db_q    <= u_db_d;
      en_b_q    <= en_b_d;
      load_b_q  <= load_b_d;
      err_q     <= err_d;
      pos_q     <= pos_d;
    end
  end

  assign bus.U_DB  = u_db_q;
  assign bus.ENPB  = en_b_q;
  assign bus.ENTB  = en_b_q;
  assign bus.LOADB = load_b_q;
  assign bus.ERR   = err_q;
  assign bus.POS   = pos_q;

endmodule

// File: tb/tb_quad_ud_driver.sv
// Directed bench for quad_ud_driver: walks, glitch/illegal handling, presets and reset.
module tb_quad_ud_driver;

  localparam int unsigned FILT_LEN = 3;
  localparam int unsigned POS_W    = 4;
  // Ticks from driving a level (just after an edge) to the strobe being visible.
  localparam int LAT = int'(FILT_LEN) + 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  quad_ud_driver_if #(.POS_W(POS_W)) bus ();

  quad_ud_driver #(.FILT_LEN(FILT_LEN), .POS_W(POS_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    bus.QA = 1'b0; bus.QB = 1'b0;
    bus.PRESET_REQ = 1'b0; bus.PRESET_VAL = '0; bus.ERR_CLR = 1'b0;
    RST = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.U_DB, bus.ENPB, bus.ENTB, bus.LOADB, bus.ERR} !== 5'b11110) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=11110", {bus.U_DB, bus.ENPB, bus.ENTB, bus.LOADB, bus.ERR});
    end
    checks++;
    if (bus.POS !== 4'd0) begin
      failures++; $display("FAIL reset_pos got=%0d want=0", bus.POS);
    end
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bus.ENPB !== 1'b1 || bus.POS !== 4'd0) begin
        failures++; $display("FAIL baseline_quiet t=%0d enpb=%b pos=%0d want 1/0", i, bus.ENPB, bus.POS);
      end
    end
  endtask

  // Drives four levels (MSB pair first), each held 10 ticks, checking strobe timing.
  task automatic do_walk(input string name, input logic [7:0] seq, input logic up, input logic [3:0] pos0);
    logic [3:0] old_pos;
    logic [3:0] new_pos;
    logic [7:0] s;
    s = seq;
    new_pos = pos0;
    for (int l = 0; l < 4; l++) begin
      {bus.QA, bus.QB} = s[7:6];
      s = s << 2;
      old_pos = new_pos;
      new_pos = up ? new_pos + 4'd1 : new_pos - 4'd1;
      for (int i = 1; i <= 10; i++) begin
        tick();
        checks++;
        if (bus.ENPB !== ((i == LAT) ? 1'b0 : 1'b1) || bus.ENTB !== ((i == LAT) ? 1'b0 : 1'b1)) begin
          failures++;
          $display("FAIL %s_strobe lvl=%0d t=%0d enpb=%b entb=%b want=%b", name, l, i,
                   bus.ENPB, bus.ENTB, (i == LAT) ? 1'b0 : 1'b1);
        end
        checks++;
        if (bus.POS !== ((i >= LAT) ? new_pos : old_pos) || bus.LOADB !== 1'b1 || bus.ERR !== 1'b0) begin
          failures++;
          $display("FAIL %s_pos lvl=%0d t=%0d pos=%0d loadb=%b err=%b want pos=%0d loadb=1 err=0", name, l, i,
                   bus.POS, bus.LOADB, bus.ERR, (i >= LAT) ? new_pos : old_pos);
        end
        if (i == LAT) begin
          checks++;
          if (bus.U_DB !== up) begin
            failures++; $display("FAIL %s_dir lvl=%0d got=%b want=%b", name, l, bus.U_DB, up);
          end
        end
      end
    end
  endtask

  task automatic test_up_walk();
    do_walk("up", 8'b10_11_01_00, 1'b1, 4'd0);
  endtask

  task automatic test_preset_zero();
    bus.PRESET_REQ = 1'b1; bus.PRESET_VAL = 4'd0;
    tick();
    bus.PRESET_REQ = 1'b0;
    checks++;
    if (bus.LOADB !== 1'b0 || bus.POS !== 4'd0 || bus.ENPB !== 1'b1) begin
      failures++; $display("FAIL preset0 loadb=%b pos=%0d enpb=%b want 0/0/1", bus.LOADB, bus.POS, bus.ENPB);
    end
    tick();
    checks++;
    if (bus.LOADB !== 1'b1 || bus.POS !== 4'd0) begin
      failures++; $display("FAIL preset0_end loadb=%b pos=%0d want 1/0", bus.LOADB, bus.POS);
    end
  endtask

  task automatic test_down_walk();
    do_walk("down", 8'b01_11_10_00, 1'b0, 4'd0);
  endtask

  task automatic test_glitch_illegal();
    bus.QA = 1'b1;
    repeat (FILT_LEN - 1) tick();
    bus.QA = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bus.ENPB !== 1'b1 || bus.ERR !== 1'b0 || bus.POS !== 4'd12) begin
        failures++; $display("FAIL glitch t=%0d enpb=%b err=%b pos=%0d want 1/0/12", i, bus.ENPB, bus.ERR, bus.POS);
      end
    end
    {bus.QA, bus.QB} = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bus.ENPB !== 1'b1 || bus.POS !== 4'd12) begin
        failures++; $display("FAIL illegal_nostep t=%0d enpb=%b pos=%0d want 1/12", i, bus.ENPB, bus.POS);
      end
    end
    checks++;
    if (bus.ERR !== 1'b1) begin
      failures++; $display("FAIL illegal_err got=%b want=1", bus.ERR);
    end
    bus.ERR_CLR = 1'b1;
    tick();
    bus.ERR_CLR = 1'b0;
    checks++;
    if (bus.ERR !== 1'b0) begin
      failures++; $display("FAIL err_clr got=%b want=0", bus.ERR);
    end
    tick();
    checks++;
    if (bus.ERR !== 1'b0) begin
      failures++; $display("FAIL err_stays_clr got=%b want=0", bus.ERR);
    end
  endtask

  // Reference is 11; 11->01 is an up step whose output cycle collides with a load.
  task automatic test_preset_collision();
    bus.QA = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      tick();
      checks++;
      if (bus.ENPB !== 1'b1) begin
        failures++; $display("FAIL coll_pre t=%0d enpb=%b want=1", i, bus.ENPB);
      end
    end
    bus.PRESET_REQ = 1'b1; bus.PRESET_VAL = 4'd9;
    tick();
    bus.PRESET_REQ = 1'b0;
    checks++;
    if (bus.LOADB !== 1'b0 || bus.POS !== 4'd9 || bus.ENPB !== 1'b1 || bus.ENTB !== 1'b1) begin
      failures++;
      $display("FAIL coll_load loadb=%b pos=%0d enpb=%b entb=%b want 0/9/1/1", bus.LOADB, bus.POS, bus.ENPB, bus.ENTB);
    end
    tick();
    checks++;
    if (bus.LOADB !== 1'b1 || bus.ENPB !== 1'b0 || bus.U_DB !== 1'b1 || bus.POS !== 4'd10) begin
      failures++;
      $display("FAIL coll_step loadb=%b enpb=%b udb=%b pos=%0d want 1/0/1/10", bus.LOADB, bus.ENPB, bus.U_DB, bus.POS);
    end
    tick();
    checks++;
    if (bus.ENPB !== 1'b1 || bus.POS !== 4'd10 || bus.ERR !== 1'b0) begin
      failures++; $display("FAIL coll_after enpb=%b pos=%0d err=%b want 1/10/0", bus.ENPB, bus.POS, bus.ERR);
    end
  endtask

  task automatic test_back_to_back_preset();
    bus.PRESET_REQ = 1'b1; bus.PRESET_VAL = 4'd3;
    tick();
    bus.PRESET_VAL = 4'd5;
    checks++;
    if (bus.LOADB !== 1'b0 || bus.POS !== 4'd3) begin
      failures++; $display("FAIL b2b_first loadb=%b pos=%0d want 0/3", bus.LOADB, bus.POS);
    end
    tick();
    bus.PRESET_REQ = 1'b0;
    checks++;
    if (bus.LOADB !== 1'b0 || bus.POS !== 4'd5) begin
      failures++; $display("FAIL b2b_second loadb=%b pos=%0d want 0/5", bus.LOADB, bus.POS);
    end
    tick();
    checks++;
    if (bus.LOADB !== 1'b1 || bus.POS !== 4'd5) begin
      failures++; $display("FAIL b2b_end loadb=%b pos=%0d want 1/5", bus.LOADB, bus.POS);
    end
  endtask

  // Reference is 01; 01->00 up step is parked behind a load, then reset lands.
  task automatic test_reset_mid();
    bus.QB = 1'b0;
    repeat (LAT - 1) tick();
    bus.PRESET_REQ = 1'b1; bus.PRESET_VAL = 4'd7;
    tick();
    bus.PRESET_REQ = 1'b0;
    checks++;
    if (bus.LOADB !== 1'b0 || bus.POS !== 4'd7) begin
      failures++; $display("FAIL rmid_load loadb=%b pos=%0d want 0/7", bus.LOADB, bus.POS);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({bus.U_DB, bus.ENPB, bus.ENTB, bus.LOADB, bus.ERR} !== 5'b11110 || bus.POS !== 4'd0) begin
      failures++;
      $display("FAIL rmid_reset ctl=%b pos=%0d want 11110/0", {bus.U_DB, bus.ENPB, bus.ENTB, bus.LOADB, bus.ERR}, bus.POS);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (bus.ENPB !== 1'b1 || bus.LOADB !== 1'b1 || bus.POS !== 4'd0) begin
        failures++;
        $display("FAIL rmid_quiet t=%0d enpb=%b loadb=%b pos=%0d want 1/1/0", i, bus.ENPB, bus.LOADB, bus.POS);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_walk();
    test_preset_zero();
    test_down_walk();
    test_glitch_illegal();
    test_preset_collision();
    test_back_to_back_preset();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
